haar_cascade_sequencer: RTL and testbench
=========================================

HAAR_CASCADE_SEQUENCER -- requirements
Module: haar_cascade_sequencer

Interface
REQ-001 Parameter NUM_STAGES, default 22: number of cascade stages evaluated per window.
REQ-002 Parameter FEAT_AW, default 12: feature-table address width.
REQ-003 Parameter STAGE_AW, default 5: stage-threshold-table address width.
REQ-004 Clk  in  1  system clock; all logic on rising edge.
REQ-005 Reset  in  1  synchronous, active-high reset.
REQ-006 start  in  1  request window evaluation; sampled only in IDLE.
REQ-007 busy  out  1  high in every state except IDLE.
REQ-008 done  out  1  one-cycle pulse; result valid.
REQ-009 is_face  out  1  window verdict; held until next accepted start or Reset.
REQ-010 feat_addr  out  FEAT_AW  feature-table read address.
REQ-011 feat_pix  in  9  integral-buffer index (0-399) for the addressed feature.
REQ-012 feat_last  in  1  addressed feature is the last feature of its stage.
REQ-013 feat_thresh  in  32  signed feature threshold.
REQ-014 feat_left  in  32  signed vote when ib_data <= feat_thresh.
REQ-015 feat_right  in  32  signed vote when ib_data > feat_thresh.
REQ-016 stage_addr  out  STAGE_AW  stage-threshold address; equals current stage counter.
REQ-017 stage_thresh  in  32  signed stage threshold.
REQ-018 ib_addr  out  9  integral-buffer read address.
REQ-019 ib_data  in  32  signed integral-buffer word.
REQ-020 All tables and the integral buffer SHALL be treated as synchronous-read: data valid the cycle after the address is presented.

Function
REQ-021 States SHALL be IDLE, FEAT_RD, PIX_RD, EVAL, STAGE_CHK, DONE.
REQ-022 IDLE, start=1: feat_addr<=0, stage<=0, acc<=0, is_face<=0, go to FEAT_RD; start=0: stay in IDLE.
REQ-023 FEAT_RD: hold feat_addr; go to PIX_RD.
REQ-024 PIX_RD: register ib_addr<=feat_pix and capture feat_last/thresh/left/right; go to EVAL.
REQ-025 EVAL: acc<=acc+(ib_data>feat_thresh ? feat_right : feat_left), signed strict compare; if captured last=1 go to STAGE_CHK, else feat_addr++ and go to FEAT_RD.
REQ-026 STAGE_CHK: if acc<stage_thresh (signed), is_face<=0 and go to DONE (early exit; no further fetches).
REQ-027 STAGE_CHK, pass, stage==NUM_STAGES-1: is_face<=1 and go to DONE.
REQ-028 STAGE_CHK, pass, otherwise: stage++, acc<=0, feat_addr++, go to FEAT_RD.
REQ-029 acc==stage_thresh SHALL count as pass.
REQ-030 DONE: done=1 for exactly this cycle; go to IDLE.
REQ-031 acc SHALL be 32-bit signed two's-complement; wraps on overflow, no saturation.
REQ-032 feat_addr SHALL wrap modulo 2^FEAT_AW; table contents guarantee no wrap in normal use.
REQ-033 With start sampled at edge 0, F features evaluated and S stage checks executed, done SHALL be high in cycle 3F+S+1.
REQ-034 start while busy=1, including the DONE cycle, SHALL be ignored.
REQ-035 stage_addr SHALL change only in STAGE_CHK, so stage_thresh is stable by the next STAGE_CHK (minimum 3 cycles later).

Reset
REQ-036 Reset=1 SHALL, at the next edge and from any state: go to IDLE, and clear busy, done, is_face, feat_addr, stage_addr, ib_addr and acc to 0.
REQ-037 Reset mid-evaluation SHALL discard the partial result; no done pulse is produced for the aborted window.

Verification
REQ-038 NUM_STAGES=1, 3 features, all ib_data>thresh, right votes 100/200/300, stage_thresh=600 -> done at cycle 11, is_face=1.
REQ-039 Stage 0 with 3 features, acc=599, stage_thresh=600 -> done at cycle 11, is_face=0, feat_addr never exceeds 2.
REQ-040 feat_thresh=-3522: ib_data=-4000 selects left; ib_data=-3522 selects left; ib_data=-3521 selects right.
REQ-041 Two stages of 3 and 12 features, both pass -> done at cycle 3*15+2+1=48, is_face=1, stage_addr sequence 0,1.
REQ-042 start pulses in cycles 5 and 11 of an active run -> ignored, exactly one done, result unchanged.
REQ-043 Reset asserted during EVAL of feature 4 -> next cycle busy=0, is_face=0, feat_addr=0, acc=0; a new start then runs normally.

Source files
------------

// File: rtl/haar_cascade_sequencer.sv
// Haar cascade window evaluator: walks the feature table stage by stage,
// accumulates signed votes and exits early on the first failing stage.
module haar_cascade_sequencer #(
  parameter int NUM_STAGES = 22,
  parameter int FEAT_AW    = 12,
  parameter int STAGE_AW   = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic                is_face,
  output logic [FEAT_AW-1:0]  feat_addr,
  input  logic [8:0]          feat_pix,
  input  logic                feat_last,
  input  logic signed [31:0]  feat_thresh,
  input  logic signed [31:0]  feat_left,
  input  logic signed [31:0]  feat_right,
  output logic [STAGE_AW-1:0] stage_addr,
  input  logic signed [31:0]  stage_thresh,
  output logic [8:0]          ib_addr,
  input  logic signed [31:0]  ib_data
);

  typedef enum logic [2:0] {
    IDLE,
    FEAT_RD,
    PIX_RD,
    EVAL,
    STAGE_CHK,
    DONE
  } state_t;

  localparam logic [FEAT_AW-1:0]  FEAT_ONE   = 1;
  localparam logic [STAGE_AW-1:0] STAGE_ONE  = 1;
  localparam logic [STAGE_AW-1:0] LAST_STAGE = STAGE_AW'(NUM_STAGES - 1);

  state_t                state_q, state_d;
  logic [FEAT_AW-1:0]    feat_addr_q, feat_addr_d;
  logic [STAGE_AW-1:0]   stage_q, stage_d;
  logic signed [31:0]    acc_q, acc_d;
  logic                  is_face_q, is_face_d;
  logic [8:0]            ib_addr_q, ib_addr_d;
  logic                  last_q, last_d;
  logic signed [31:0]    thresh_q, thresh_d;
  logic signed [31:0]    left_q, left_d;
  logic signed [31:0]    right_q, right_d;
  logic signed [31:0]    vote;

  assign vote = (ib_data > thresh_q) ? right_q : left_q;

  always_comb begin
    state_d     = state_q;
    feat_addr_d = feat_addr_q;
    stage_d     = stage_q;
    acc_d       = acc_q;
    is_face_d   = is_face_q;
    ib_addr_d   = ib_addr_q;
    last_d      = last_q;
    thresh_d    = thresh_q;
    left_d      = left_q;
    right_d     = right_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          feat_addr_d = '0;
          stage_d     = '0;
          acc_d       = '0;
          is_face_d   = 1'b0;
          state_d     = FEAT_RD;
        end
      end
      FEAT_RD: state_d = PIX_RD;
      PIX_RD: begin
        ib_addr_d = feat_pix;
        last_d    = feat_last;
        thresh_d  = feat_thresh;
        left_d    = feat_left;
        right_d   = feat_right;
        state_d   = EVAL;
      end
      EVAL: begin
        acc_d = acc_q + vote;
        if (last_q) begin
          state_d = STAGE_CHK;
        end else begin
          feat_addr_d = feat_addr_q + FEAT_ONE;
          state_d     = FEAT_RD;
        end
      end
      STAGE_CHK: begin
        // Equality with the stage threshold counts as a pass.
        if (acc_q < stage_thresh) begin
          is_face_d = 1'b0;
          state_d   = DONE;
        end else if (stage_q == LAST_STAGE) begin
          is_face_d = 1'b1;
          state_d   = DONE;
        end else begin
          stage_d     = stage_q + STAGE_ONE;
          acc_d       = '0;
          feat_addr_d = feat_addr_q + FEAT_ONE;
          state_d     = FEAT_RD;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      feat_addr_q <= '0;
      stage_q     <= '0;
      acc_q       <= '0;
      is_face_q   <= 1'b0;
      ib_addr_q   <= '0;
      last_q      <= 1'b0;
      thresh_q    <= '0;
      left_q      <= '0;
      right_q     <= '0;
    end else begin
      state_q     <= state_d;
      feat_addr_q <= feat_addr_d;
      stage_q     <= stage_d;
      acc_q       <= acc_d;
      is_face_q   <= is_face_d;
      ib_addr_q   <= ib_addr_d;
      last_q      <= last_d;
      thresh_q    <= thresh_d;
      left_q      <= left_d;
      right_q     <= right_d;
    end
  end

  // The buffer address is presented as it is being loaded, so the synchronous
  // read lands in EVAL rather than one cycle later.
  assign ib_addr    = ib_addr_d;
  assign feat_addr  = feat_addr_q;
  assign stage_addr = stage_q;
  assign is_face    = is_face_q;
  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE);

endmodule

// File: tb/tb_haar_cascade_sequencer.sv
// Scoreboard bench for haar_cascade_sequencer: a window-level reference model
// predicts verdict, latency and address extents for each accepted start.
module tb_haar_cascade_sequencer;

  localparam int NS       = 2;
  localparam int FEAT_AW  = 12;
  localparam int STAGE_AW = 5;

  logic                clk = 1'b0;
  logic                reset;
  logic                start;
  logic                busy, done, is_face;
  logic [FEAT_AW-1:0]  feat_addr;
  logic [8:0]          feat_pix;
  logic                feat_last;
  logic signed [31:0]  feat_thresh, feat_left, feat_right;
  logic [STAGE_AW-1:0] stage_addr;
  logic signed [31:0]  stage_thresh;
  logic [8:0]          ib_addr;
  logic signed [31:0]  ib_data;

  typedef struct {
    bit face;
    int lat;
    int max_fa;
    int max_st;
  } exp_t;

  exp_t exp_q[$];
  int   tests_run = 0;
  int   tests_failed = 0;
  int   cyc = 0;
  int   start_cyc = 0;

  int   nf[NS];
  int   ft_pix[64];
  bit   ft_last[64];
  int   ft_thr[64];
  int   ft_left[64];
  int   ft_right[64];
  int   st_thr[4];
  int   ib_mem[512];

  haar_cascade_sequencer #(
    .NUM_STAGES(NS),
    .FEAT_AW(FEAT_AW),
    .STAGE_AW(STAGE_AW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .busy(busy),
    .done(done),
    .is_face(is_face),
    .feat_addr(feat_addr),
    .feat_pix(feat_pix),
    .feat_last(feat_last),
    .feat_thresh(feat_thresh),
    .feat_left(feat_left),
    .feat_right(feat_right),
    .stage_addr(stage_addr),
    .stage_thresh(stage_thresh),
    .ib_addr(ib_addr),
    .ib_data(ib_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous-read tables and integral buffer.
  always @(posedge clk) begin
    feat_pix     <= 9'(ft_pix[feat_addr[5:0]]);
    feat_last    <= ft_last[feat_addr[5:0]];
    feat_thresh  <= ft_thr[feat_addr[5:0]];
    feat_left    <= ft_left[feat_addr[5:0]];
    feat_right   <= ft_right[feat_addr[5:0]];
    stage_thresh <= st_thr[stage_addr[1:0]];
    ib_data      <= ib_mem[ib_addr];
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, $signed(actual), $signed(expected));
    end
  endtask

  function automatic int feat_base(input int s);
    int b = 0;
    for (int i = 0; i < s; i++) b += nf[i];
    return b;
  endfunction

  function automatic int vote_of(input int idx);
    return (ib_mem[ft_pix[idx]] > ft_thr[idx]) ? ft_right[idx] : ft_left[idx];
  endfunction

  function automatic int stage_sum(input int s);
    int a = 0;
    for (int i = 0; i < nf[s]; i++) a += vote_of(feat_base(s) + i);
    return a;
  endfunction

  // Window-level model: features run stage after stage; a stage whose vote
  // sum falls below its threshold ends the window as a non-face.
  function automatic exp_t run_model();
    exp_t e;
    int f = 0;
    int stages = 0;
    e.face = 1'b1;
    for (int s = 0; s < NS; s++) begin
      f += nf[s];
      stages++;
      if (stage_sum(s) < st_thr[s]) begin
        e.face = 1'b0;
        break;
      end
    end
    e.lat    = 3 * f + stages + 1;
    e.max_fa = f - 1;
    e.max_st = stages - 1;
    return e;
  endfunction

  task automatic clear_tables();
    for (int i = 0; i < 64; i++) begin
      ft_pix[i] = 0; ft_last[i] = 1'b0; ft_thr[i] = 0; ft_left[i] = 0; ft_right[i] = 0;
    end
    for (int i = 0; i < 512; i++) ib_mem[i] = 0;
    for (int i = 0; i < 4; i++) st_thr[i] = 0;
  endtask

  task automatic set_last();
    for (int i = 0; i < 64; i++) ft_last[i] = 1'b0;
    for (int s = 0; s < NS; s++) ft_last[feat_base(s) + nf[s] - 1] = 1'b1;
  endtask

  task automatic random_window(input bit wide);
    for (int s = 0; s < NS; s++) nf[s] = int'($urandom_range(1, 5));
    for (int i = 0; i < 512; i++) ib_mem[i] = int'($urandom_range(0, 120)) - 60;
    for (int i = 0; i < 64; i++) begin
      ft_pix[i]   = int'($urandom_range(0, 399));
      ft_thr[i]   = int'($urandom_range(0, 100)) - 50;
      ft_left[i]  = wide ? int'($urandom) : int'($urandom_range(0, 200)) - 100;
      ft_right[i] = wide ? int'($urandom) : int'($urandom_range(0, 200)) - 100;
    end
    set_last();
    for (int s = 0; s < NS; s++) st_thr[s] = stage_sum(s) + int'($urandom_range(0, 2)) - 1;
  endtask

  task automatic applyStimulus(input bit push_exp, output bit exp_face);
    exp_t e;
    e = run_model();
    exp_face = e.face;
    @(negedge clk);
    if (push_exp) exp_q.push_back(e);
    start = 1'b1;
    start_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_window(input bit pulses);
    bit ef;
    int k = 0;
    applyStimulus(1'b1, ef);
    while (busy && k < 200) begin
      if (pulses) start = ((cyc - start_cyc) == 5) || ((cyc - start_cyc) == 11) || done;
      @(negedge clk);
      k++;
    end
    start = 1'b0;
    checkOutput("run_finished", {31'd0, busy}, 32'd0);
    if (busy) begin
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      exp_q.delete();
    end
    @(negedge clk);
    checkOutput("idle_after_done", {31'd0, busy}, 32'd0);
    checkOutput("is_face_held", {31'd0, is_face}, {31'd0, ef});
  endtask

  // Monitor: every done pulse is matched against the oldest expectation.
  initial begin
    int max_fa = 0;
    int max_st = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (busy) begin
          if (int'(feat_addr) > max_fa) max_fa = int'(feat_addr);
          if (int'(stage_addr) > max_st) max_st = int'(stage_addr);
        end else begin
          max_fa = 0;
          max_st = 0;
        end
        if (done) begin
          if (exp_q.size() == 0) begin
            checkOutput("unexpected_done", {31'd0, done}, 32'd0);
          end else begin
            e = exp_q.pop_front();
            checkOutput("is_face", {31'd0, is_face}, {31'd0, e.face});
            checkOutput("latency", cyc - start_cyc, e.lat);
            checkOutput("max_feat_addr", max_fa, e.max_fa);
            checkOutput("max_stage_addr", max_st, e.max_st);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bit dummy;
    int k;
    reset = 1'b1;
    start = 1'b0;
    clear_tables();
    repeat (3) @(negedge clk);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_done", {31'd0, done}, 32'd0);
    checkOutput("rst_is_face", {31'd0, is_face}, 32'd0);
    checkOutput("rst_feat_addr", {20'd0, feat_addr}, 32'd0);
    checkOutput("rst_stage_addr", {27'd0, stage_addr}, 32'd0);
    checkOutput("rst_ib_addr", {23'd0, ib_addr}, 32'd0);
    reset = 1'b0;

    // Stage 0 sums to 599 against 600: early exit after three features.
    nf[0] = 3; nf[1] = 1;
    for (int i = 0; i < 4; i++) begin
      ft_pix[i] = 10 + i; ft_thr[i] = 0; ft_left[i] = -5; ib_mem[10 + i] = 50;
    end
    ft_right[0] = 100; ft_right[1] = 200; ft_right[2] = 299; ft_right[3] = 7; ft_left[3] = 7;
    st_thr[0] = 600; st_thr[1] = 0;
    set_last();
    run_window(1'b0);

    // Sum equal to the threshold passes.
    ft_right[2] = 300;
    run_window(1'b0);

    // Strict signed compare at a negative feature threshold.
    for (int i = 0; i < 3; i++) begin
      ft_pix[i] = 20 + i; ft_thr[i] = -3522; ft_left[i] = 1; ft_right[i] = 1000;
    end
    ib_mem[20] = -4000; ib_mem[21] = -3522; ib_mem[22] = -3521;
    st_thr[0] = 1003;
    run_window(1'b0);
    st_thr[0] = 1002; st_thr[1] = 100;
    run_window(1'b0);

    // Two stages of 3 and 12 features, both passing, with ignored start pulses.
    clear_tables();
    nf[0] = 3; nf[1] = 12;
    for (int i = 0; i < 15; i++) begin
      ft_pix[i] = 30 + i; ib_mem[30 + i] = 10; ft_thr[i] = 0; ft_right[i] = 5; ft_left[i] = -5;
    end
    st_thr[0] = 15; st_thr[1] = 60;
    set_last();
    run_window(1'b1);

    // Reset during EVAL of the fourth feature discards the window.
    nf[0] = 6; nf[1] = 2;
    st_thr[0] = 0; st_thr[1] = 0;
    set_last();
    applyStimulus(1'b0, dummy);
    k = 0;
    while ((cyc - start_cyc) < 12 && k < 50) begin
      @(negedge clk);
      k++;
    end
    checkOutput("busy_before_reset", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("abort_busy", {31'd0, busy}, 32'd0);
    checkOutput("abort_done", {31'd0, done}, 32'd0);
    checkOutput("abort_is_face", {31'd0, is_face}, 32'd0);
    checkOutput("abort_feat_addr", {20'd0, feat_addr}, 32'd0);
    checkOutput("abort_stage_addr", {27'd0, stage_addr}, 32'd0);
    checkOutput("abort_ib_addr", {23'd0, ib_addr}, 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    nf[0] = 3; nf[1] = 12;
    st_thr[0] = 15; st_thr[1] = 60;
    set_last();
    run_window(1'b0);

    for (int t = 0; t < 40; t++) begin
      random_window((t % 4) == 3);
      run_window((t % 5) == 0);
    end

    repeat (3) @(negedge clk);
    checkOutput("pending_expectations", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
